// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl
//   Control-flow recovery sequencer for the 5-stage pipeline.
//   - This block holds a direct-mapped BHT of 2-bit saturating counters.
//     The BHT is indexed by pc[IDX_BITS+1:2].
//   - It gives IF a combinational taken/not-taken prediction for conditional branches.
//   - It trains the BHT from each resolved EX branch.
//   - On a mispredict it issues a one-cycle registered PC redirect plus a flush of IF/ID and ID/EX.
//   - It counts resolved and mispredicted branches.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   if_pc              PC of the instruction in IF
//   if_is_branch       IF predecode: conditional branch opcode
//   pred_taken         prediction for if_pc (combinational)
//   ex_branch          valid conditional branch in EX
//   ex_stall           EX frozen; EX inputs ignored
//   ex_pc              PC of the EX branch
//   ex_decision        resolved branch outcome
//   ex_pred_taken      prediction carried down with the branch
//   ex_target          branch target address
//   redirect           registered; load redirect_pc into PC
//   redirect_pc        corrected fetch address (holds when redirect=0)
//   flush_if_id        registered; bubble IF/ID
//   flush_id_ex        registered; bubble ID/EX
//   branch_count       resolved branches (wraps)
//   mispredict_count   mispredicted branches (wraps)
module branch_predict_ctrl #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             if_is_branch,
  output logic             pred_taken,
  input  logic             ex_branch,
  input  logic             ex_stall,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_decision,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;

  typedef enum logic {
    NORMAL,
    REDIRECT
  } state_e;

  state_e              state_q;
  logic [1:0]          bht_q [ENTRIES];
  logic                redirect_q;
  logic                flush_if_id_q;
  logic                flush_id_ex_q;
  logic [PC_W-1:0]     redirect_pc_q;
  logic [CNT_W-1:0]    branch_cnt_q;
  logic [CNT_W-1:0]    branch_cnt_d;
  logic [CNT_W-1:0]    mispred_cnt_q;
  logic [CNT_W-1:0]    mispred_cnt_d;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                res;
  logic                mispredict;
  logic [1:0]          bht_cur;
  logic [1:0]          bht_d;
  logic [PC_W-1:0]     redirect_pc_d;
  logic                unused_pc_bits;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];

  // Only the index bits of if_pc feed the table lookup.
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_BITS+2], if_pc[1:0]};

  // The table read happens before this cycle's training write lands.
  // As a result, a same-index update becomes visible only on the next cycle.
  assign pred_taken = if_is_branch & bht_q[if_idx][1];

  // The slot following a mispredict is wrong-path.
  // For that reason, the qualifier also requires the FSM to be in NORMAL.
  assign res        = ex_branch & ~ex_stall & (state_q == NORMAL);
  assign mispredict = res & (ex_decision != ex_pred_taken);

  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_d   = bht_cur;
    if (ex_decision) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res)        branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    if (mispredict) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  assign redirect_pc_d = ex_decision ? ex_target : (ex_pc + PC_W'(4));

  // The FSM and all of its registered outputs live in this one block.
  // Because the reset is asynchronous, reset also aborts a redirect that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= NORMAL;
      redirect_q    <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (mispredict) begin
            state_q       <= REDIRECT;
            redirect_q    <= 1'b1;
            flush_if_id_q <= 1'b1;
            flush_id_ex_q <= 1'b1;
            redirect_pc_q <= redirect_pc_d;
          end else begin
            redirect_q    <= 1'b0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
          end
        end
        REDIRECT: begin
          state_q       <= NORMAL;
          redirect_q    <= 1'b0;
          flush_if_id_q <= 1'b0;
          flush_id_ex_q <= 1'b0;
        end
        default: begin
          state_q       <= NORMAL;
          redirect_q    <= 1'b0;
          flush_if_id_q <= 1'b0;
          flush_id_ex_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (res) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush_if_id      = flush_if_id_q;
  assign flush_id_ex      = flush_id_ex_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule
